// File: rtl/audio_mem_read_master.sv
// audio_mem_read_master: Avalon-MM block reader feeding an in-order Avalon-ST sample stream.
// Ports: start/abort/base_addr/word_count in, busy/done/aborted out, m_* read master, st_* source.
module audio_mem_read_master #(
  parameter int ADDR_W      = 15,
  parameter int LEN_W       = 13,
  parameter int FIFO_DEPTH  = 8,
  parameter int MAX_PENDING = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic [3:0]        m_byteenable,
  input  logic              m_waitrequest,
  input  logic [31:0]       m_readdata,
  input  logic              m_readdatavalid,
  output logic [31:0]       st_data,
  output logic              st_valid,
  input  logic              st_ready
);

  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = CW + 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic [PW-1:0]     pending;
  logic [CW-1:0]     count;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              ab_flag;
  logic [31:0]       mem [FIFO_DEPTH];

  logic              acc;
  logic              ret;
  logic              pop;
  logic              push;
  logic              hold;
  logic              issue;
  logic [ADDR_W-1:0] addr_n;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  rem_n;
  logic [PW-1:0]     pend_n;
  logic [CW-1:0]     cnt_n;
  logic [OW-1:0]     occ_n;
  logic              unused_ok;

  assign unused_ok    = ^base_addr[1:0];
  assign start_addr   = {base_addr[ADDR_W-1:2], 2'b00};
  assign m_byteenable = 4'hF;
  assign st_valid     = (count != '0);
  assign st_data      = st_valid ? mem[rd_ptr] : '0;

  // Credit is judged on next-cycle occupancy so that
  // back-to-back reads sustain one word per clock.
  always_comb begin
    acc    = m_read & ~m_waitrequest;
    ret    = m_readdatavalid & (pending != '0);
    pop    = st_valid & st_ready;
    push   = ret & (state == S_RUN) & ~abort;
    hold   = m_read & m_waitrequest;
    addr_n = acc ? addr + ADDR_W'(4) : addr;
    rem_n  = remaining - LEN_W'(acc);
    pend_n = pending + PW'(acc) - PW'(ret);
    cnt_n  = count + CW'(push) - CW'(pop);
    occ_n  = OW'(pend_n) + OW'(cnt_n);
    issue  = (rem_n != '0)
           && (pend_n < PW'(MAX_PENDING))
           && (occ_n < OW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= m_readdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      pending   <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ab_flag   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      m_read    <= 1'b0;
      m_address <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= start_addr;
            m_address <= start_addr;
            remaining <= word_count;
            pending   <= '0;
            ab_flag   <= 1'b0;
            if (word_count == '0) begin
              state <= S_DONE;
            end else begin
              state  <= S_RUN;
              busy   <= 1'b1;
              m_read <= 1'b1;
            end
          end
        end
        S_RUN: begin
          addr      <= addr_n;
          remaining <= rem_n;
          pending   <= pend_n;
          if (abort) begin
            // A stalled request cannot be withdrawn.
            state   <= S_FLUSH;
            ab_flag <= 1'b1;
            m_read  <= hold;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
          end else begin
            m_read <= hold | issue;
            if (!hold) m_address <= addr_n;
            count <= cnt_n;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (remaining == '0 && pending == '0
                && count == '0 && !m_read) begin
              state <= S_DONE;
            end
          end
        end
        S_FLUSH: begin
          addr      <= addr_n;
          remaining <= rem_n;
          pending   <= pend_n;
          m_read    <= hold;
          if (pending == '0 && !m_read) state <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b1;
          aborted <= ab_flag;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_mem_read_master.sv
// tb_audio_mem_read_master: randomized bench with a queue-based model of slave, FIFO and stream.
// Drives and samples on the falling edge; the DUT acts on the rising edge.
module tb_audio_mem_read_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [14:0] base_addr;
  logic [12:0] word_count;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [14:0] m_address;
  logic        m_read;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_ready;

  audio_mem_read_master dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .abort           (abort),
    .base_addr       (base_addr),
    .word_count      (word_count),
    .busy            (busy),
    .done            (done),
    .aborted         (aborted),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_byteenable    (m_byteenable),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .st_data         (st_data),
    .st_valid        (st_valid),
    .st_ready        (st_ready)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          wr_pct = 0;
  int          rdy_mode = 0;
  int          rsp_lat = 1;
  bit          force_wr = 0;
  bit          in_run = 0;
  bit          flushing = 0;
  bit          prev_hold = 0;
  logic [14:0] prev_addr = '0;
  logic [14:0] x_base;
  int          x_cnt;
  int          n_acc, n_ret, n_pop, t_done;
  logic [31:0] first_pop, last_pop;
  logic [31:0] fifo_q[$];
  logic [31:0] rsp_data[$];
  int          rsp_due[$];
  logic [14:0] acc_log[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [14:0] a);
    return 32'h1000_0000 + 32'(a[14:2]);
  endfunction

  function automatic logic [14:0] exp_addr(input int k);
    return 15'(int'(x_base) + 4 * k);
  endfunction

  // One clock: check outputs against the model, pick new inputs,
  // then advance the model by what the next rising edge will do.
  task automatic step();
    bit acc, pop, ab;
    chk("st_valid", 32'(st_valid), 32'(fifo_q.size() != 0));
    if (fifo_q.size() != 0) chk("st_data", st_data, fifo_q[0]);
    if (prev_hold) begin
      chk("hold_read", 32'(m_read), 32'd1);
      chk("hold_addr", 32'(m_address), 32'(prev_addr));
    end
    if (m_read) begin
      chk("read_in_xfer", 32'(in_run), 32'd1);
      if (in_run) begin
        chk("req_addr", 32'(m_address), 32'(exp_addr(n_acc)));
        chk("req_count", 32'(n_acc < x_cnt), 32'd1);
        if (flushing) chk("no_new_req", 32'(prev_hold), 32'd1);
      end
    end
    if (in_run) begin
      chk("pending_max", 32'(n_acc - n_ret <= 4), 32'd1);
      chk("fifo_max", 32'(fifo_q.size() <= 8), 32'd1);
    end

    m_waitrequest = force_wr || ($urandom_range(0, 99) < wr_pct);
    case (rdy_mode)
      0: st_ready = 1'b1;
      1: st_ready = (cyc % 4 == 0);
      2: st_ready = 1'b0;
      default: st_ready = 1'($urandom_range(0, 1));
    endcase
    if (rsp_due.size() != 0 && rsp_due[0] <= cyc) begin
      m_readdatavalid = 1'b1;
      m_readdata = rsp_data.pop_front();
      void'(rsp_due.pop_front());
    end else begin
      m_readdatavalid = 1'b0;
      m_readdata = $urandom;
    end

    acc = reset_n && m_read && !m_waitrequest;
    pop = reset_n && st_valid && st_ready && fifo_q.size() != 0;
    ab = reset_n && abort && in_run && !flushing;
    if (acc) begin
      rsp_data.push_back(mem_word(m_address));
      rsp_due.push_back(cyc + rsp_lat);
      acc_log.push_back(m_address);
      n_acc++;
    end
    if (pop && !ab) begin
      chk("stream", st_data, mem_word(exp_addr(n_pop)));
      if (n_pop == 0) first_pop = st_data;
      last_pop = st_data;
      void'(fifo_q.pop_front());
      n_pop++;
    end
    if (m_readdatavalid && in_run && reset_n) begin
      n_ret++;
      if (!flushing) fifo_q.push_back(m_readdata);
    end
    if (ab) begin
      flushing = 1;
      fifo_q.delete();
    end
    prev_hold = reset_n && m_read && m_waitrequest;
    prev_addr = m_address;
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_xfer(input logic [14:0] b, input int n,
                          input int ab_after, input int budget);
    int ab_t;
    bit got;
    x_base = {b[14:2], 2'b00};
    x_cnt = n;
    n_acc = 0;
    n_ret = 0;
    n_pop = 0;
    flushing = 0;
    fifo_q.delete();
    acc_log.delete();
    start = 1'b1;
    base_addr = b;
    word_count = 13'(n);
    in_run = (n != 0);
    step();
    start = 1'b0;
    chk("first_read", 32'(m_read), 32'(n != 0));
    ab_t = -1;
    got = 0;
    t_done = -1;
    for (int t = 0; t < budget && !got; t++) begin
      if (done) begin
        got = 1;
        t_done = t;
      end else begin
        chk("busy", 32'(busy), 32'(n != 0));
        if (ab_after >= 0) begin
          if (ab_t < 0 && n_acc == ab_after) begin
            force_wr = 1;
            ab_t = 0;
          end else if (ab_t >= 0) begin
            ab_t++;
          end
          abort = (ab_t == 2);
          if (ab_t == 2) chk("abort_held", 32'(m_read), 32'd1);
          if (ab_t == 4) force_wr = 0;
        end
        step();
      end
    end
    abort = 1'b0;
    force_wr = 0;
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end else begin
      chk("busy_at_done", 32'(busy), 32'd0);
      chk("aborted", 32'(aborted), 32'(ab_after >= 0));
      chk("returns", 32'(n_ret), 32'(n_acc));
      if (ab_after < 0) begin
        chk("words_out", 32'(n_pop), 32'(n));
        chk("reqs", 32'(n_acc), 32'(n));
      end
    end
    in_run = 0;
    step();
    chk("done_once", 32'(done), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_aborted"}, 32'(aborted), 32'd0);
    chk({tag, "_m_read"}, 32'(m_read), 32'd0);
    chk({tag, "_m_address"}, 32'(m_address), 32'd0);
    chk({tag, "_byteenable"}, 32'(m_byteenable), 32'hF);
    chk({tag, "_st_valid"}, 32'(st_valid), 32'd0);
    chk({tag, "_st_data"}, st_data, 32'd0);
  endtask

  task automatic reset_test();
    bit hit;
    rsp_lat = 3;
    wr_pct = 0;
    rdy_mode = 0;
    x_base = 15'h0300;
    x_cnt = 20;
    n_acc = 0;
    n_ret = 0;
    n_pop = 0;
    flushing = 0;
    fifo_q.delete();
    acc_log.delete();
    start = 1'b1;
    base_addr = 15'h0300;
    word_count = 13'd20;
    in_run = 1;
    step();
    start = 1'b0;
    hit = 0;
    for (int k = 0; k < 50 && !hit; k++) begin
      if (n_acc - n_ret == 3) hit = 1;
      else step();
    end
    chk("rst_pending3", 32'(hit), 32'd1);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    in_run = 0;
    flushing = 0;
    prev_hold = 0;
    fifo_q.delete();
    @(negedge clk);
    cyc++;
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 10 && rsp_data.size() != 0; k++) step();
    chk("rst_drain", 32'(rsp_data.size()), 32'd0);
    chk("rst_idle_valid", 32'(st_valid), 32'd0);
    rsp_lat = 1;
    run_xfer(15'h0400, 4, -1, 60);
    chk("rst_restart_last", last_pop, 32'h1000_0103);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    base_addr = '0;
    word_count = '0;
    m_waitrequest = 1'b0;
    m_readdata = '0;
    m_readdatavalid = 1'b0;
    st_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // basic streaming, 1 word/clk
    run_xfer(15'h0100, 16, -1, 100);
    chk("basic_nreq", 32'(acc_log.size()), 32'd16);
    if (acc_log.size() == 16) begin
      chk("basic_addr0", 32'(acc_log[0]), 32'h0100);
      chk("basic_addr15", 32'(acc_log[15]), 32'h013C);
    end
    chk("basic_first", first_pop, 32'h1000_0040);
    chk("basic_last", last_pop, 32'h1000_004F);
    chk("basic_lat", 32'(t_done >= 0 && t_done <= 22), 32'd1);

    // backpressure on both sides
    wr_pct = 50;
    rdy_mode = 1;
    run_xfer(15'h0200, 32, -1, 1000);
    chk("bp_last", last_pop, 32'h1000_009F);

    // zero length
    wr_pct = 0;
    rdy_mode = 0;
    run_xfer(15'h0040, 0, -1, 10);
    chk("zero_lat", 32'(t_done), 32'd1);
    chk("zero_reqs", 32'(acc_log.size()), 32'd0);

    // address wrap
    run_xfer(15'h7FF8, 4, -1, 50);
    chk("wrap_nreq", 32'(acc_log.size()), 32'd4);
    if (acc_log.size() == 4) begin
      chk("wrap_a0", 32'(acc_log[0]), 32'h7FF8);
      chk("wrap_a1", 32'(acc_log[1]), 32'h7FFC);
      chk("wrap_a2", 32'(acc_log[2]), 32'h0000);
      chk("wrap_a3", 32'(acc_log[3]), 32'h0004);
    end
    chk("wrap_first", first_pop, 32'h1000_1FFE);
    chk("wrap_last", last_pop, 32'h1000_0001);

    // abort with a stalled 7th request
    rdy_mode = 2;
    run_xfer(15'h1000, 100, 6, 400);
    chk("abort_reqs", 32'(n_acc), 32'd7);
    rdy_mode = 0;
    run_xfer(15'h2000, 2, -1, 50);
    chk("post_abort_last", last_pop, 32'h1000_0801);

    reset_test();

    for (int i = 0; i < 6; i++) begin
      logic [14:0] b;
      int n;
      b = 15'($urandom);
      n = $urandom_range(1, 40);
      wr_pct = $urandom_range(0, 70);
      rdy_mode = ($urandom_range(0, 2) == 2) ? 3 : $urandom_range(0, 1);
      run_xfer(b, n, -1, n * 40 + 60);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
